// File: rtl/arb_hs_mux_pkg.sv
// Shared types for arb_handshake_mux: buffer state encoding and the buffered beat record.
package arb_hs_mux_pkg;

    localparam int unsigned BeatDataW = 32;
    localparam int unsigned BeatIdxW  = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [BeatDataW-1:0] data;
        logic                 last;
        logic [BeatIdxW-1:0]  idx;
    } beat_t;

endpackage

// File: rtl/arb_handshake_mux_fixed_priority_arbiter.sv
// Fixed-priority one-hot arbiter; bit 0 has the highest priority.
module fixed_priority_arbiter #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_handshake_mux.sv
// Packet-preserving fixed-priority merge of NumReq valid/ready streams into a 2-entry output buffer.
// Optional stall counter output enabled by defining ARB_HS_MUX_STALL_CNT_EN.
module arb_handshake_mux
    import arb_hs_mux_pkg::*;
#(
    parameter  int unsigned NumReq    = 4,
    parameter  int unsigned DataWidth = BeatDataW,
    parameter  int unsigned StallCntW = 16,
    localparam int unsigned IdxW      = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [NumReq-1:0]           in_valid_i,
    output logic [NumReq-1:0]           in_ready_o,
    input  logic [NumReq*DataWidth-1:0] in_data_i,
    input  logic [NumReq-1:0]           in_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DataWidth-1:0]        out_data_o,
    output logic                        out_last_o,
    output logic [IdxW-1:0]             out_idx_o
`ifdef ARB_HS_MUX_STALL_CNT_EN
    ,
    output logic [StallCntW-1:0]        stall_cnt_o
`endif
);

    buf_state_e        state_q, state_d;
    logic              lock_q, lock_d;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    beat_t             head_q, head_d;
    beat_t             skid_q, skid_d;
    logic              out_valid_q, out_valid_d;

    logic [NumReq-1:0] arb_gnt;
    logic [NumReq-1:0] lock_onehot;
    logic [NumReq-1:0] gnt_c;
    logic [IdxW-1:0]   win_idx;
    beat_t             in_beat;
    logic              push;
    logic              pop;

    fixed_priority_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .req_i (in_valid_i),
        .gnt_o (arb_gnt)
    );

    // A locked channel keeps the grant even while idle so packets are never interleaved.
    assign lock_onehot = NumReq'(1) << lock_idx_q;
    assign gnt_c       = lock_q ? (in_valid_i & lock_onehot) : arb_gnt;
    assign in_ready_o  = gnt_c & {NumReq{state_q != FULL}};
    assign push        = |(in_valid_i & in_ready_o);
    assign pop         = out_valid_q & out_ready_i;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_c[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        in_beat      = '0;
        in_beat.data = BeatDataW'(in_data_i[win_idx*DataWidth +: DataWidth]);
        in_beat.last = in_last_i[win_idx];
        in_beat.idx  = BeatIdxW'(win_idx);
    end

    // State register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: occupancy follows push/pop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Output/datapath logic: head entry drives out_*, skid holds the second beat
    always_comb begin
        head_d      = head_q;
        skid_d      = skid_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = (state_d != EMPTY);
        unique case (state_q)
            EMPTY: if (push) head_d = in_beat;
            ONE: begin
                if (push && pop) begin
                    head_d = in_beat;
                end else if (push) begin
                    skid_d = in_beat;
                end
            end
            FULL:    if (pop) head_d = skid_q;
            default: ;
        endcase
        if (push) begin
            lock_d     = !in_beat.last;
            lock_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            head_q      <= '0;
            skid_q      <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = DataWidth'(head_q.data);
    assign out_last_o  = head_q.last;
    assign out_idx_o   = IdxW'(head_q.idx);

`ifdef ARB_HS_MUX_STALL_CNT_EN
    logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of back-pressured cycles since the last pop
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pop) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    if (StallCntW == 0) begin : g_no_stall_cnt
    end
`endif

endmodule

// File: tb/tb_arb_handshake_mux.sv
// Directed, table-driven bench for arb_handshake_mux with hand-written multi-cycle sequences.
module tb_arb_handshake_mux;

    localparam int unsigned NumReq    = 4;
    localparam int unsigned DataWidth = 32;
`ifdef ARB_HS_MUX_STALL_CNT_EN
    localparam int unsigned StallCntW = 3;
`else
    localparam int unsigned StallCntW = 16;
`endif

    localparam logic [31:0] A1 = 32'h0000_00A1, A2 = 32'h0000_00A2;
    localparam logic [31:0] B0 = 32'h0000_00B0, B1 = 32'h0000_00B1, B2 = 32'h0000_00B2;
    localparam logic [31:0] C0 = 32'h0000_00C0, C1 = 32'h0000_00C1, C2 = 32'h0000_00C2;
    localparam logic [31:0] D0 = 32'h0000_00D0, Z  = 32'h0000_0000;

    logic                        clk_i = 1'b0;
    logic                        arst_ni = 1'b0;
    logic [NumReq-1:0]           in_valid_i = '0;
    logic [NumReq-1:0]           in_ready_o;
    logic [NumReq*DataWidth-1:0] in_data_i = '0;
    logic [NumReq-1:0]           in_last_i = '0;
    logic                        out_valid_o;
    logic                        out_ready_i = 1'b0;
    logic [DataWidth-1:0]        out_data_o;
    logic                        out_last_o;
    logic [1:0]                  out_idx_o;
`ifdef ARB_HS_MUX_STALL_CNT_EN
    logic [StallCntW-1:0]        stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    arb_handshake_mux #(
        .NumReq    (NumReq),
        .DataWidth (DataWidth),
        .StallCntW (StallCntW)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_idx_o   (out_idx_o)
`ifdef ARB_HS_MUX_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic [3:0]       vld;
        logic [3:0]       last;
        logic [3:0][31:0] data;
        logic             ordy;
        logic [3:0]       exp_rdy;
        logic             exp_ov;
        logic [31:0]      exp_od;
        logic [1:0]       exp_idx;
        logic             exp_last;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic ordy, input logic [3:0] erdy, input logic eov,
                                input logic [31:0] eod, input logic [1:0] eidx, input logic elast);
        vec_t v;
        v.vld = vld; v.last = last; v.ordy = ordy;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.exp_rdy = erdy; v.exp_ov = eov; v.exp_od = eod; v.exp_idx = eidx; v.exp_last = elast;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] last,
                         input logic [3:0][31:0] data, input logic ordy);
        in_valid_i  = vld;
        in_last_i   = last;
        in_data_i   = data;
        out_ready_i = ordy;
    endtask

    // Called at posedge+1: drive, check ready, clock, check registered outputs
    task automatic apply(input vec_t v, input int i);
        drive(v.vld, v.last, v.data, v.ordy);
        #1;
        chk($sformatf("v%0d in_ready", i), 32'(in_ready_o), 32'(v.exp_rdy));
        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(v.exp_ov));
        if (v.exp_ov) begin
            chk($sformatf("v%0d out_data", i), out_data_o, v.exp_od);
            chk($sformatf("v%0d out_idx", i), 32'(out_idx_o), 32'(v.exp_idx));
            chk($sformatf("v%0d out_last", i), 32'(out_last_o), 32'(v.exp_last));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] d;

        // two-channel burst, back-to-back delivery
        vecs[0]  = mk(4'b0110, 4'b1111, Z,  A1, A2, Z, 1'b1, 4'b0010, 1'b1, A1, 2'd1, 1'b1);
        vecs[1]  = mk(4'b0100, 4'b1111, Z,  Z,  A2, Z, 1'b1, 4'b0100, 1'b1, A2, 2'd2, 1'b1);
        vecs[2]  = mk(4'b0000, 4'b0000, Z,  Z,  Z,  Z, 1'b1, 4'b0000, 1'b0, Z,  2'd0, 1'b0);
        // ch2 packet locks out ch0 until its last beat
        vecs[3]  = mk(4'b0100, 4'b0000, Z,  Z,  C0, Z, 1'b1, 4'b0100, 1'b1, C0, 2'd2, 1'b0);
        vecs[4]  = mk(4'b0101, 4'b0000, D0, Z,  C1, Z, 1'b1, 4'b0100, 1'b1, C1, 2'd2, 1'b0);
        vecs[5]  = mk(4'b0101, 4'b0100, D0, Z,  C2, Z, 1'b1, 4'b0100, 1'b1, C2, 2'd2, 1'b1);
        vecs[6]  = mk(4'b0001, 4'b0001, D0, Z,  Z,  Z, 1'b1, 4'b0001, 1'b1, D0, 2'd0, 1'b1);
        vecs[7]  = mk(4'b0000, 4'b0000, Z,  Z,  Z,  Z, 1'b1, 4'b0000, 1'b0, Z,  2'd0, 1'b0);
        // back-pressure fills the buffer, then drains in order
        vecs[8]  = mk(4'b0001, 4'b0001, B0, Z,  Z,  Z, 1'b0, 4'b0001, 1'b1, B0, 2'd0, 1'b1);
        vecs[9]  = mk(4'b0001, 4'b0001, B1, Z,  Z,  Z, 1'b0, 4'b0001, 1'b1, B0, 2'd0, 1'b1);
        vecs[10] = mk(4'b0001, 4'b0001, B2, Z,  Z,  Z, 1'b0, 4'b0000, 1'b1, B0, 2'd0, 1'b1);
        vecs[11] = mk(4'b0001, 4'b0001, B2, Z,  Z,  Z, 1'b1, 4'b0000, 1'b1, B1, 2'd0, 1'b1);
        vecs[12] = mk(4'b0001, 4'b0001, B2, Z,  Z,  Z, 1'b1, 4'b0001, 1'b1, B2, 2'd0, 1'b1);
        vecs[13] = mk(4'b0000, 4'b0000, Z,  Z,  Z,  Z, 1'b1, 4'b0000, 1'b0, Z,  2'd0, 1'b0);

        #1;
        chk("rst out_valid", 32'(out_valid_o), 32'd0);
        chk("rst out_data", out_data_o, 32'd0);
        chk("rst out_last", 32'(out_last_o), 32'd0);
        chk("rst out_idx", 32'(out_idx_o), 32'd0);
        chk("rst in_ready", 32'(in_ready_o), 32'd0);
`ifdef ARB_HS_MUX_STALL_CNT_EN
        chk("rst stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
        #11;
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], i);
        end

        // ch1 streams 8 beats at full rate
        for (int k = 0; k < 8; k++) begin
            d = '0;
            d[1] = 32'h0000_00E0 + 32'(k);
            drive(4'b0010, (k == 7) ? 4'b0010 : 4'b0000, d, 1'b1);
            #1;
            chk($sformatf("stream%0d in_ready", k), 32'(in_ready_o), 32'h2);
            @(posedge clk_i);
            #1;
            chk($sformatf("stream%0d out_valid", k), 32'(out_valid_o), 32'd1);
            chk($sformatf("stream%0d out_data", k), out_data_o, 32'h0000_00E0 + 32'(k));
            chk($sformatf("stream%0d out_idx", k), 32'(out_idx_o), 32'd1);
        end
        d = '0;
        drive(4'b0000, 4'b0000, d, 1'b1);
        @(posedge clk_i);
        #1;
        chk("stream drain out_valid", 32'(out_valid_o), 32'd0);

        // reset while locked on ch3 and full
        d = '0;
        d[3] = 32'h0000_00F0;
        drive(4'b1000, 4'b0000, d, 1'b0);
        @(posedge clk_i);
        #1;
        d[3] = 32'h0000_00F1;
        drive(4'b1000, 4'b0000, d, 1'b0);
        #1;
        chk("lockfull in_ready", 32'(in_ready_o), 32'h8);
        @(posedge clk_i);
        #1;
        chk("lockfull in_ready full", 32'(in_ready_o), 32'h0);
        chk("lockfull out_data", out_data_o, 32'h0000_00F0);
        d = '0;
        drive(4'b0000, 4'b0000, d, 1'b0);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid_o), 32'd0);
        chk("midrst out_data", out_data_o, 32'd0);
        @(posedge clk_i);
        #2;
        arst_ni = 1'b1;
        d[0] = 32'h0000_0070;
        d[3] = 32'h0000_0073;
        drive(4'b1001, 4'b1001, d, 1'b1);
        #1;
        chk("postrst in_ready", 32'(in_ready_o), 32'h1);
        @(posedge clk_i);
        #1;
        chk("postrst out_valid", 32'(out_valid_o), 32'd1);
        chk("postrst out_idx", 32'(out_idx_o), 32'd0);
        chk("postrst out_data", out_data_o, 32'h0000_0070);
        d = '0;
        drive(4'b0000, 4'b0000, d, 1'b1);
        @(posedge clk_i);
        #1;
        chk("postrst drain", 32'(out_valid_o), 32'd0);

`ifdef ARB_HS_MUX_STALL_CNT_EN
        // stall counter saturates at all-ones, clears on pop
        d = '0;
        d[0] = 32'h0000_0090;
        drive(4'b0001, 4'b0001, d, 1'b0);
        @(posedge clk_i);
        #1;
        chk("stall start", 32'(stall_cnt_o), 32'd0);
        d = '0;
        drive(4'b0000, 4'b0000, d, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("stall%0d", k), 32'(stall_cnt_o), (k > 7) ? 32'd7 : 32'(k));
        end
        chk("stall held data", out_data_o, 32'h0000_0090);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("stall clear", 32'(stall_cnt_o), 32'd0);
        chk("stall pop valid", 32'(out_valid_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
